// File: rtl/lut_layer_seq_pkg.sv
// lut_layer_pkg: shared definitions for the LUT layer sequencer.
//   - FSM state encoding (IDLE / RUN / DONE)
//   - conn_idx(): extracts one entry of the flattened connectivity map
package lut_layer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Widest connectivity map conn_idx() accepts. Callers zero-extend their
  // map to this width so one function serves every layer size.
  localparam int CONN_MAX_W = 4096;

  // Entry (n,k) of the map: the input bit that drives lut_addr[k] of neuron n.
  function automatic int conn_idx(input logic [CONN_MAX_W-1:0] conn,
                                  input int n, input int k,
                                  input int fanin, input int idx_w);
    int idx;
    idx = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < idx_w) idx[b] = conn[(n * fanin + k) * idx_w + b];
    end
    return idx;
  endfunction

endpackage

// File: rtl/lut_layer_seq_if.sv
// lut_layer_seq_if: input-vector and result-vector valid/ready streams.
//   in_valid/in_ready/in_data    : activation vector into the sequencer
//   out_valid/out_ready/out_data : result vector out of the sequencer
// modport slave is the sequencer side, master is the traffic side.
interface lut_layer_seq_if #(
  parameter int IN_W    = 12,
  parameter int NEURONS = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_data;
  logic               out_valid;
  logic               out_ready;
  logic [NEURONS-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lut_layer_seq_gather.sv
// lut_addr_gather: combinational address builder.
//   en   : high while the sequencer is evaluating neurons
//   act  : latched activation vector
//   sel  : neuron index being evaluated
//   addr : FANIN-bit LUT address; 0 when en is low
// Each neuron's address bits are wired straight from the map, then the
// current neuron's address is picked with a mux on sel.
module lut_addr_gather
  import lut_layer_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int NEURONS = 4,
  parameter int FANIN   = 6,
  parameter int IDX_W   = 4,
  parameter logic [NEURONS*FANIN*IDX_W-1:0] CONN = '0,
  parameter int SEL_W   = 2
) (
  input  logic             en,
  input  logic [IN_W-1:0]  act,
  input  logic [SEL_W-1:0] sel,
  output logic [FANIN-1:0] addr
);

  localparam logic [CONN_MAX_W-1:0] CONN_EXT = CONN_MAX_W'(CONN);

  logic [NEURONS*FANIN-1:0] tab_flat;

  for (genvar gi = 0; gi < NEURONS; gi++) begin : g_n
    for (genvar gk = 0; gk < FANIN; gk++) begin : g_k
      localparam int IDX = conn_idx(CONN_EXT, gi, gk, FANIN, IDX_W);
      // A map entry pointing past the vector drives a hard 0, never X.
      if (IDX < IN_W) begin : g_hit
        assign tab_flat[gi*FANIN+gk] = act[IDX];
      end else begin : g_miss
        assign tab_flat[gi*FANIN+gk] = 1'b0;
      end
    end
  end

  always_comb begin
    addr = '0;
    if (en) begin
      for (int n = 0; n < NEURONS; n++) begin
        if (sel == SEL_W'(n)) addr = tab_flat[n*FANIN +: FANIN];
      end
    end
  end

endmodule

// File: rtl/lut_layer_seq.sv
// lut_layer_seq: time-multiplexed sequencer for one quantised LUT layer.
//   clk, rst  : clock, asynchronous active-high reset
//   io        : input/result valid-ready streams (slave side)
//   lut_sel   : neuron index presented to the external LUT bank
//   lut_addr  : LUT address for that neuron
//   lut_data  : combinational 1-bit LUT result
//   busy      : high while neurons are being evaluated
// One neuron is evaluated per cycle; a finished vector is held in DONE
// until accepted, and a new vector may be taken in that same cycle.
module lut_layer_seq
  import lut_layer_pkg::*;
#(
  parameter int IN_W    = 12,
  parameter int NEURONS = 4,
  parameter int FANIN   = 6,
  parameter int IDX_W   = 4,
  parameter logic [NEURONS*FANIN*IDX_W-1:0] CONN = '0,
  localparam int SEL_W  = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  lut_layer_seq_if.slave   io,
  output logic [SEL_W-1:0] lut_sel,
  output logic [FANIN-1:0] lut_addr,
  input  logic             lut_data,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(NEURONS - 1);

  logic [1:0]         state_reg;
  logic [SEL_W-1:0]   cnt_reg;
  logic [IN_W-1:0]    act_reg;
  logic [NEURONS-1:0] res_reg;
  logic               run;

  assign run         = (state_reg == ST_RUN);
  assign busy        = run;
  assign lut_sel     = run ? cnt_reg : '0;
  assign io.out_valid = (state_reg == ST_DONE);
  assign io.out_data  = io.out_valid ? res_reg : '0;
  // In DONE, readiness follows the consumer so a new vector can be taken
  // in the same cycle the result leaves.
  assign io.in_ready  = (state_reg == ST_IDLE) ||
                        ((state_reg == ST_DONE) && io.out_ready);

  lut_addr_gather #(
    .IN_W(IN_W), .NEURONS(NEURONS), .FANIN(FANIN),
    .IDX_W(IDX_W), .CONN(CONN), .SEL_W(SEL_W)
  ) u_gather (
    .en  (run),
    .act (act_reg),
    .sel (cnt_reg),
    .addr(lut_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      act_reg   <= '0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (io.in_valid) begin
            act_reg   <= io.in_data;
            cnt_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_reg[cnt_reg] <= lut_data;
          if (cnt_reg == LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + SEL_W'(1);
          end
        end
        ST_DONE: begin
          if (io.out_ready) begin
            if (io.in_valid) begin
              act_reg   <= io.in_data;
              cnt_reg   <= '0;
              state_reg <= ST_RUN;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lut_layer_seq.sv
// Testbench for lut_layer_seq: randomized vectors checked against a
// behavioural model of the layer (map = (2n+k) mod 12, LUT = all-ones detect
// or neuron-parity in the alternate mode).
module tb_lut_layer_seq;

  localparam int IN_W    = 12;
  localparam int NEURONS = 4;
  localparam int FANIN   = 6;
  localparam int IDX_W   = 4;

  function automatic logic [NEURONS*FANIN*IDX_W-1:0] make_conn();
    logic [NEURONS*FANIN*IDX_W-1:0] c;
    c = '0;
    for (int n = 0; n < NEURONS; n++)
      for (int k = 0; k < FANIN; k++)
        c[(n*FANIN+k)*IDX_W +: IDX_W] = IDX_W'((2*n + k) % 12);
    return c;
  endfunction

  localparam logic [NEURONS*FANIN*IDX_W-1:0] CONN_TB = make_conn();

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lut_sel;
  logic [5:0] lut_addr;
  logic       lut_data;
  logic       busy;
  int         lut_mode;

  always #5 clk = ~clk;

  lut_layer_seq_if #(.IN_W(IN_W), .NEURONS(NEURONS)) bus ();

  lut_layer_seq #(
    .IN_W(IN_W), .NEURONS(NEURONS), .FANIN(FANIN), .IDX_W(IDX_W), .CONN(CONN_TB)
  ) dut (
    .clk(clk), .rst(rst), .io(bus),
    .lut_sel(lut_sel), .lut_addr(lut_addr), .lut_data(lut_data), .busy(busy)
  );

  // External LUT bank.
  assign lut_data = (lut_mode == 1) ? lut_sel[0] : (lut_addr == 6'h3F);

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] model_addr(input logic [11:0] v, input int n);
    logic [5:0] a;
    for (int k = 0; k < FANIN; k++) a[k] = v[(2*n + k) % 12];
    return a;
  endfunction

  function automatic logic [3:0] model_out(input logic [11:0] v, input int mode);
    logic [3:0] r;
    for (int n = 0; n < NEURONS; n++)
      r[n] = (mode == 1) ? n[0] : (model_addr(v, n) == 6'h3F);
    return r;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".out_data"},  32'(bus.out_data),  32'd0);
    chk({tag, ".busy"},      32'(busy),          32'd0);
    chk({tag, ".lut_sel"},   32'(lut_sel),       32'd0);
    chk({tag, ".lut_addr"},  32'(lut_addr),      32'd0);
  endtask

  // Checks the four RUN cycles of vector v (starting at the current negedge).
  task automatic chk_run(input logic [11:0] v, input string tag);
    for (int n = 0; n < NEURONS; n++) begin
      chk({tag, ".busy"},      32'(busy),          32'd1);
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, ".lut_sel"},   32'(lut_sel),       32'(n));
      chk({tag, ".lut_addr"},  32'(lut_addr),      32'(model_addr(v, n)));
      @(negedge clk);
    end
  endtask

  // Full transaction from IDLE: accept, run, check result, drain.
  task automatic run_vec(input logic [11:0] v, input string tag);
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = 12'($urandom);
    chk_run(v, tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".out_data"},  32'(bus.out_data),  32'(model_out(v, lut_mode)));
    $display("vec %s in=%03h out=%01h", tag, v, bus.out_data);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    logic [11:0] v1, v2;
    logic [3:0]  q[$];
    int sent, got, last, cyc;
    bit acc;

    rst = 1'b1;
    lut_mode = 0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    // Address gather and fixed patterns.
    run_vec(12'h0FF, "gather");
    run_vec(12'hFFF, "ones");
    run_vec(12'h000, "zeros");
    for (int i = 0; i < 6; i++) run_vec(12'($urandom), "rand");

    // Reset pulse mid-RUN.
    bus.in_valid = 1'b1;
    bus.in_data = 12'hFFF;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("midrun.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    // Back-pressure in DONE with a new vector waiting.
    v1 = 12'($urandom);
    v2 = 12'($urandom);
    bus.in_valid = 1'b1;
    bus.in_data = v1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk_run(v1, "bp1");
    bus.in_valid = 1'b1;
    bus.in_data = v2;
    for (int i = 0; i < 10; i++) begin
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp.out_data",  32'(bus.out_data),  32'(model_out(v1, 0)));
      chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp.release_in_ready", 32'(bus.in_ready), 32'd1);
    $display("vec bp1 in=%03h out=%01h", v1, bus.out_data);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk_run(v2, "bp2");
    chk("bp2.out_data", 32'(bus.out_data), 32'(model_out(v2, 0)));
    $display("vec bp2 in=%03h out=%01h", v2, bus.out_data);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk_idle("bp_done");

    // Streaming: 8 vectors, both sides always willing.
    sent = 0; got = 0; last = -1; cyc = 0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 12'($urandom);
    while (got < 8 && cyc < 200) begin
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("stream.unexpected", 32'(bus.out_data), 32'hDEAD);
        end else begin
          chk("stream.out_data", 32'(bus.out_data), 32'(q.pop_front()));
        end
        if (last >= 0) chk("stream.gap", 32'(cyc - last), 32'd5);
        $display("vec stream #%0d out=%01h cyc=%0d", got, bus.out_data, cyc);
        last = cyc;
        got++;
      end
      acc = bus.in_ready && (sent < 8);
      if (acc) begin
        q.push_back(model_out(bus.in_data, 0));
        sent++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (sent == 8) bus.in_valid = 1'b0;
        else bus.in_data = 12'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    chk("stream.count", 32'(got), 32'd8);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk_idle("stream_end");

    // Alternate LUT: result bit n follows neuron index parity.
    lut_mode = 1;
    for (int i = 0; i < 3; i++) begin
      v1 = 12'($urandom);
      run_vec(v1, "alt");
      chk("alt.model", 32'(model_out(v1, 1)), 32'hA);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
